// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage.
// Owns the fetch PC and drives a request/grant/response instruction-memory
// port. Returned instructions land in a 2-entry queue whose head feeds the
// IF/ID register. Redirects from EX flush the queue and mark every request
// still in flight for discard. Credit-based issue (outstanding + queued <= 2)
// guarantees that every response finds space in the queue.
module if_fetch_stage #(
   parameter int unsigned          BUS_WIDTH  = 32,
   parameter int unsigned          DATA_WIDTH = 32,
   parameter logic [BUS_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   // redirect from EX
   input  logic                  jump_en,
   input  logic [BUS_WIDTH-1:0]  jump_addr,
   // instruction-memory port
   output logic                  imem_req,
   output logic [BUS_WIDTH-1:0]  imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   // IF/ID interface
   input  logic                  allow_in_id,
   output logic [BUS_WIDTH-1:0]  pc_if,
   output logic [DATA_WIDTH-1:0] instruction_if,
   output logic                  valid_if,
   output logic                  ready_go_if
);

   // ------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------

   // Word-align an address by clearing its two low bits.
   function automatic logic [BUS_WIDTH-1:0] align_word(input logic [BUS_WIDTH-1:0] a);
      return a & ~BUS_WIDTH'(3);
   endfunction

   // Next sequential fetch address; wraps naturally at the top of the space.
   function automatic logic [BUS_WIDTH-1:0] next_pc(input logic [BUS_WIDTH-1:0] a);
      return a + BUS_WIDTH'(4);
   endfunction

   // Decrement of a 0..2 counter that saturates at zero.
   function automatic logic [1:0] sat_dec(input logic [1:0] v);
      return (v == 2'd0) ? 2'd0 : v - 2'd1;
   endfunction

   // Increment of a 0..2 counter that saturates at two.
   function automatic logic [1:0] sat_inc(input logic [1:0] v);
      return (v == 2'd2) ? 2'd2 : v + 2'd1;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------

   logic [BUS_WIDTH-1:0]  fetch_pc;
   logic [1:0]            outstanding;   // granted, not yet responded (incl. ones to drop)
   logic [1:0]            drop_cnt;      // oldest in-flight responses to discard
   logic [1:0]            q_count;       // live entries in the instruction queue

   // PC tags of in-flight requests, in grant order
   logic [BUS_WIDTH-1:0]  tag_pc_p0 [2];
   logic                  tag_wr_ptr;
   logic                  tag_rd_ptr;

   // Instruction queue (head = q_rd_ptr)
   logic [BUS_WIDTH-1:0]  q_pc_p1    [2];
   logic [DATA_WIDTH-1:0] q_instr_p1 [2];
   logic                  q_wr_ptr;
   logic                  q_rd_ptr;

   // ------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------

   logic [2:0]            credit_used;
   logic                  grant;
   logic                  rsp_drop;
   logic                  rsp_push;
   logic                  q_pop;
   logic                  q_nonempty;
   logic [1:0]            outstanding_nxt;
   logic [1:0]            drop_cnt_nxt;
   logic [1:0]            q_count_nxt;

   // Request issue, handshake and response classification.
   always_comb begin
      credit_used = {1'b0, outstanding} + {1'b0, q_count};
      imem_req    = ~rst & ~jump_en & (credit_used < 3'd2);
      grant       = imem_req & imem_gnt;
      // a response is discarded if it was outstanding at a redirect, or if
      // it arrives in the redirect cycle itself
      rsp_drop    = imem_rvalid & ((drop_cnt != 2'd0) | jump_en);
      rsp_push    = imem_rvalid & ~rsp_drop;
      q_nonempty  = (q_count != 2'd0);
      q_pop       = valid_if & ready_go_if & allow_in_id;
   end

   // Next value of the outstanding-request counter.
   always_comb begin
      outstanding_nxt = outstanding;
      case ({grant, imem_rvalid})
         2'b10:   outstanding_nxt = sat_inc(outstanding);
         2'b01:   outstanding_nxt = sat_dec(outstanding);
         default: outstanding_nxt = outstanding;
      endcase
   end

   // Next value of the drop counter; a redirect recomputes it from the
   // requests that remain in flight once this cycle's response is consumed.
   always_comb begin
      drop_cnt_nxt = drop_cnt;
      if (jump_en) begin
         drop_cnt_nxt = imem_rvalid ? sat_dec(outstanding) : outstanding;
      end else if (rsp_drop) begin
         drop_cnt_nxt = sat_dec(drop_cnt);
      end
   end

   // Next value of the queue occupancy.
   always_comb begin
      q_count_nxt = q_count;
      if (jump_en) begin
         q_count_nxt = 2'd0;
      end else begin
         case ({rsp_push, q_pop})
            2'b10:   q_count_nxt = sat_inc(q_count);
            2'b01:   q_count_nxt = sat_dec(q_count);
            default: q_count_nxt = q_count;
         endcase
      end
   end

   // Outputs toward memory and the IF/ID register; head fields read as zero when empty.
   always_comb begin
      imem_addr      = fetch_pc;
      ready_go_if    = 1'b1;
      valid_if       = q_nonempty & ~jump_en;
      pc_if          = q_nonempty ? q_pc_p1[q_rd_ptr]    : '0;
      instruction_if = q_nonempty ? q_instr_p1[q_rd_ptr] : '0;
   end

   // ------------------------------------------------------------------
   // Sequential logic
   // ------------------------------------------------------------------

   // Control state: fetch PC, counters and FIFO pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         outstanding <= 2'd0;
         drop_cnt    <= 2'd0;
         q_count     <= 2'd0;
         tag_wr_ptr  <= 1'b0;
         tag_rd_ptr  <= 1'b0;
         q_wr_ptr    <= 1'b0;
         q_rd_ptr    <= 1'b0;
      end else begin
         if (jump_en) begin
            fetch_pc <= align_word(jump_addr);
         end else if (grant) begin
            fetch_pc <= next_pc(fetch_pc);
         end

         outstanding <= outstanding_nxt;
         drop_cnt    <= drop_cnt_nxt;
         q_count     <= q_count_nxt;

         if (grant) begin
            tag_wr_ptr <= ~tag_wr_ptr;
         end
         if (imem_rvalid) begin
            tag_rd_ptr <= ~tag_rd_ptr;
         end

         if (jump_en) begin
            q_wr_ptr <= 1'b0;
            q_rd_ptr <= 1'b0;
         end else begin
            if (rsp_push) begin
               q_wr_ptr <= ~q_wr_ptr;
            end
            if (q_pop) begin
               q_rd_ptr <= ~q_rd_ptr;
            end
         end
      end
   end

   // ---- request stage (p0): capture PC tag of each granted request ----
   always_ff @(posedge clk) begin
      if (grant) begin
         tag_pc_p0[tag_wr_ptr] <= fetch_pc;
      end
   end

   // ---- response stage (p1): store accepted instruction with its PC tag ----
   always_ff @(posedge clk) begin
      if (rsp_push) begin
         q_pc_p1[q_wr_ptr]    <= tag_pc_p0[tag_rd_ptr];
         q_instr_p1[q_wr_ptr] <= imem_rdata;
      end
   end

   // ------------------------------------------------------------------
   // Protocol assertions
   // ------------------------------------------------------------------

   // A response must correspond to a granted request.
   a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
      imem_rvalid |-> (outstanding != 2'd0));

   // In-flight requests plus queued instructions never exceed queue depth.
   a_credit_bound: assert property (@(posedge clk) disable iff (rst)
      credit_used <= 3'd2);

   // An accepted response always finds a free slot (or a slot freed this cycle).
   a_rsp_room: assert property (@(posedge clk) disable iff (rst)
      rsp_push |-> ((q_count < 2'd2) || q_pop));

   // The drop counter never exceeds the number of requests in flight.
   a_drop_bound: assert property (@(posedge clk) disable iff (rst)
      drop_cnt <= outstanding);

   // The reset PC has to be word-aligned.
   a_reset_pc_aligned: assert property (@(posedge clk)
      RESET_PC[1:0] == 2'b00);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed per-cycle vector table for the
// corner cases, then randomized traffic against a queue-based reference model.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        allow_in_id;

   logic        imem_req, valid_if, ready_go_if;
   logic [31:0] imem_addr, pc_if, instruction_if;
   logic        w_imem_req, w_valid_if, w_ready_go_if;
   logic [31:0] w_imem_addr, w_pc_if, w_instruction_if;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   if_fetch_stage #(.BUS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .jump_en(jump_en), .jump_addr(jump_addr),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .allow_in_id(allow_in_id), .pc_if(pc_if), .instruction_if(instruction_if),
      .valid_if(valid_if), .ready_go_if(ready_go_if));

   // Second instance with a reset PC just below the top of the address space.
   if_fetch_stage #(.BUS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .rst(rst), .jump_en(jump_en), .jump_addr(jump_addr),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .allow_in_id(allow_in_id), .pc_if(w_pc_if), .instruction_if(w_instruction_if),
      .valid_if(w_valid_if), .ready_go_if(w_ready_go_if));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          chk;
      logic        rst, jmp;
      logic [31:0] jaddr;
      logic        gnt, rv;
      logic [31:0] rdata;
      logic        allow;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_pc, e_ins;
      bit          chkw;
      logic [31:0] w_addr, w_pc;
   } vec_t;

   vec_t vec[$];

   function automatic logic [31:0] D(input logic [31:0] a);
      return 32'h1000_0000 | a;
   endfunction

   function automatic void add(input logic r, input logic j, input logic [31:0] ja,
                               input logic g, input logic rv, input logic [31:0] rd,
                               input logic al, input logic er, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ep, input logic [31:0] ei);
      vec_t v;
      v.chk = 1; v.rst = r; v.jmp = j; v.jaddr = ja; v.gnt = g; v.rv = rv;
      v.rdata = rd; v.allow = al; v.e_req = er; v.e_addr = ea; v.e_vld = ev;
      v.e_pc = ep; v.e_ins = ei; v.chkw = 0; v.w_addr = 0; v.w_pc = 0;
      vec.push_back(v);
   endfunction

   // Reset row with no check, used to separate sections.
   function automatic void pre();
      add(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      vec[vec.size()-1].chk = 0;
   endfunction

   function automatic void wlast(input logic [31:0] wa, input logic [31:0] wp);
      vec[vec.size()-1].chkw   = 1;
      vec[vec.size()-1].w_addr = wa;
      vec[vec.size()-1].w_pc   = wp;
   endfunction

   function automatic void build_table();
      // streaming after reset, 1-cycle latency, also drives the wrap instance
      add(1,0,0,1,0,0,1,     0,0,0,0,0);          wlast(32'hFFFF_FFF8, 0);
      add(0,0,0,1,0,0,1,     1,0,0,0,0);          wlast(32'hFFFF_FFF8, 0);
      add(0,0,0,1,1,D(0),1,  1,4,0,0,0);          wlast(32'hFFFF_FFFC, 0);
      add(0,0,0,1,1,D(4),1,  0,8,1,0,D(0));       wlast(32'h0000_0000, 32'hFFFF_FFF8);
      add(0,0,0,1,0,0,1,     1,8,1,4,D(4));       wlast(32'h0000_0000, 32'hFFFF_FFFC);
      add(0,0,0,1,1,D(8),1,  1,12,0,0,0);         wlast(32'h0000_0004, 0);
      add(0,0,0,1,1,D(12),1, 0,16,1,8,D(8));      wlast(32'h0000_0008, 0);
      add(0,0,0,1,0,0,1,     1,16,1,12,D(12));    wlast(32'h0000_0008, 32'h0000_0004);
      // IF/ID stalled from reset: queue fills, fetching stops, then resumes
      pre();
      add(1,0,0,1,0,0,0,     0,0,0,0,0);
      add(0,0,0,1,0,0,0,     1,0,0,0,0);
      add(0,0,0,1,1,D(0),0,  1,4,0,0,0);
      add(0,0,0,1,1,D(4),0,  0,8,1,0,D(0));
      add(0,0,0,1,0,0,0,     0,8,1,0,D(0));
      add(0,0,0,1,0,0,0,     0,8,1,0,D(0));
      add(0,0,0,1,0,0,1,     0,8,1,0,D(0));
      add(0,0,0,1,0,0,1,     1,8,1,4,D(4));
      add(0,0,0,1,1,D(8),1,  1,12,0,0,0);
      add(0,0,0,1,1,D(12),1, 0,16,1,8,D(8));
      // grant withheld for 3 cycles
      pre();
      add(1,0,0,1,0,0,1,     0,0,0,0,0);
      add(0,0,0,0,0,0,1,     1,0,0,0,0);
      add(0,0,0,0,0,0,1,     1,0,0,0,0);
      add(0,0,0,0,0,0,1,     1,0,0,0,0);
      add(0,0,0,1,0,0,1,     1,0,0,0,0);
      add(0,0,0,1,1,D(0),1,  1,4,0,0,0);
      add(0,0,0,1,1,D(4),1,  0,8,1,0,D(0));
      add(0,0,0,1,0,0,1,     1,8,1,4,D(4));
      // redirect with two requests (8, 12) in flight
      pre();
      add(1,0,0,1,0,0,1,     0,0,0,0,0);
      add(0,0,0,1,0,0,1,     1,0,0,0,0);
      add(0,0,0,1,1,D(0),1,  1,4,0,0,0);
      add(0,0,0,1,1,D(4),1,  0,8,1,0,D(0));
      add(0,0,0,1,0,0,1,     1,8,1,4,D(4));
      add(0,0,0,1,0,0,1,     1,12,0,0,0);
      add(0,1,32'h103,1,0,0,1, 0,16,0,0,0);
      add(0,0,0,1,1,D(8),1,  0,32'h100,0,0,0);
      add(0,0,0,1,1,D(12),1, 1,32'h100,0,0,0);
      add(0,0,0,1,1,D(32'h100),1, 1,32'h104,0,0,0);
      add(0,0,0,1,1,D(32'h104),1, 0,32'h108,1,32'h100,D(32'h100));
      add(0,0,0,1,0,0,1,     1,32'h108,1,32'h104,D(32'h104));
      // redirect coinciding with a response, one in flight, one queued
      pre();
      add(1,0,0,1,0,0,0,     0,0,0,0,0);
      add(0,0,0,1,0,0,0,     1,0,0,0,0);
      add(0,0,0,1,1,D(0),0,  1,4,0,0,0);
      add(0,1,32'h200,1,1,D(4),0, 0,8,0,0,D(0));
      add(0,0,0,1,0,0,1,     1,32'h200,0,0,0);
      add(0,0,0,1,1,D(32'h200),1, 1,32'h204,0,0,0);
      add(0,0,0,1,1,D(32'h204),1, 0,32'h208,1,32'h200,D(32'h200));
   endfunction

   // ---------------- reference model for random traffic ----------------
   typedef struct { logic [31:0] pc; bit killed; } fl_t;
   typedef struct { logic [31:0] pc; logic [31:0] ins; } ib_t;
   typedef struct { logic [31:0] addr; int ready; } pend_t;

   fl_t         m_fl[$];   // requests in flight, oldest first
   ib_t         m_ib[$];   // instructions waiting for IF/ID
   logic [31:0] m_pc;
   pend_t       mem[$];    // memory-side pending responses

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_9E17;
   endfunction

   task automatic do_reset();
      rst = 1; jump_en = 0; jump_addr = 0; imem_gnt = 0; imem_rvalid = 0;
      imem_rdata = 0; allow_in_id = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        e_req, e_vld, hs_dut;
      logic [31:0] e_pc, e_ins, a_dut;
      int          rdy;
      fl_t         f;

      build_table();
      do_reset();

      // directed vectors
      for (int i = 0; i < vec.size(); i++) begin
         rst         = vec[i].rst;
         jump_en     = vec[i].jmp;
         jump_addr   = vec[i].jaddr;
         imem_gnt    = vec[i].gnt;
         imem_rvalid = vec[i].rv;
         imem_rdata  = vec[i].rv ? vec[i].rdata : $urandom;
         allow_in_id = vec[i].allow;
         #1;
         if (vec[i].chk) begin
            check($sformatf("vec%0d imem_req", i), {31'b0, imem_req}, {31'b0, vec[i].e_req});
            check($sformatf("vec%0d imem_addr", i), imem_addr, vec[i].e_addr);
            check($sformatf("vec%0d valid_if", i), {31'b0, valid_if}, {31'b0, vec[i].e_vld});
            check($sformatf("vec%0d pc_if", i), pc_if, vec[i].e_pc);
            check($sformatf("vec%0d instruction_if", i), instruction_if, vec[i].e_ins);
            check($sformatf("vec%0d ready_go_if", i), {31'b0, ready_go_if}, 32'd1);
         end
         if (vec[i].chkw) begin
            check($sformatf("vec%0d wrap imem_addr", i), w_imem_addr, vec[i].w_addr);
            check($sformatf("vec%0d wrap pc_if", i), w_pc_if, vec[i].w_pc);
         end
         @(posedge clk);
         @(negedge clk);
      end

      // randomized traffic
      do_reset();
      m_fl.delete(); m_ib.delete(); mem.delete(); m_pc = 32'h0;
      for (int t = 0; t < 3000; t++) begin
         rst         = (t < 2) || ($urandom_range(0, 399) == 0);
         jump_en     = !rst && ($urandom_range(0, 19) == 0);
         jump_addr   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                   : $urandom;
         imem_gnt    = ($urandom_range(0, 9) < 7);
         allow_in_id = ($urandom_range(0, 3) != 0);
         imem_rvalid = !rst && (mem.size() != 0) && (mem[0].ready <= t);
         imem_rdata  = imem_rvalid ? mem_word(mem[0].addr) : $urandom;
         #1;
         e_req = !rst && !jump_en && ((m_fl.size() + m_ib.size()) < 2);
         e_vld = (m_ib.size() != 0) && !jump_en;
         e_pc  = (m_ib.size() != 0) ? m_ib[0].pc  : 32'h0;
         e_ins = (m_ib.size() != 0) ? m_ib[0].ins : 32'h0;
         check($sformatf("rnd%0d imem_req", t), {31'b0, imem_req}, {31'b0, e_req});
         check($sformatf("rnd%0d imem_addr", t), imem_addr, m_pc);
         check($sformatf("rnd%0d valid_if", t), {31'b0, valid_if}, {31'b0, e_vld});
         check($sformatf("rnd%0d pc_if", t), pc_if, e_pc);
         check($sformatf("rnd%0d instruction_if", t), instruction_if, e_ins);
         check($sformatf("rnd%0d ready_go_if", t), {31'b0, ready_go_if}, 32'd1);

         hs_dut = imem_req & imem_gnt;
         a_dut  = imem_addr;

         if (rst) begin
            m_fl.delete(); m_ib.delete(); m_pc = 32'h0;
            mem.delete();
         end else begin
            if (e_vld && allow_in_id) void'(m_ib.pop_front());
            if (imem_rvalid && (m_fl.size() != 0)) begin
               f = m_fl.pop_front();
               if (!f.killed && !jump_en) m_ib.push_back('{pc: f.pc, ins: imem_rdata});
            end
            if (jump_en) begin
               m_ib.delete();
               foreach (m_fl[k]) m_fl[k].killed = 1;
               m_pc = jump_addr & ~32'h3;
            end else if (e_req && imem_gnt) begin
               m_fl.push_back('{pc: m_pc, killed: 0});
               m_pc = m_pc + 32'd4;
            end
            if (imem_rvalid) void'(mem.pop_front());
            if (hs_dut) begin
               rdy = t + int'($urandom_range(1, 3));
               if ((mem.size() != 0) && (mem[mem.size()-1].ready >= rdy))
                  rdy = mem[mem.size()-1].ready + 1;
               mem.push_back('{addr: a_dut, ready: rdy});
            end
         end
         @(posedge clk);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that owns the fetch PC and drives a request/grant/response instruction-memory port.
- Buffers returned instructions in a 2-entry queue.
- Presents {pc_if, instruction_if, valid_if, ready_go_if} to the IF/ID pipeline register, which back-pressures via allow_in_id.
- Handles branch/jump redirects from EX by flushing buffered instructions and discarding in-flight responses.

Parameters:
- BUS_WIDTH, 32, address/PC width.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- jump_en  input  1  redirect request from EX (taken branch/jump), single-cycle pulse or level.
- jump_addr  input  BUS_WIDTH  redirect target; bits [1:0] ignored (treated as 0).
- imem_req  output  1  fetch request valid.
- imem_addr  output  BUS_WIDTH  fetch address (current fetch PC).
- imem_gnt  input  1  memory accepts the request this cycle (handshake = imem_req & imem_gnt).
- imem_rvalid  input  1  response data valid; responses return in order, at least 1 cycle after their grant.
- imem_rdata  input  DATA_WIDTH  response instruction.
- allow_in_id  input  1  IF/ID register can accept an entry this cycle.
- pc_if  output  BUS_WIDTH  PC of the queue-head instruction.
- instruction_if  output  DATA_WIDTH  queue-head instruction.
- valid_if  output  1  queue head holds a live instruction.
- ready_go_if  output  1  stage has finished processing its head entry.

Behaviour:
- Reset (rst=1 at posedge): fetch_pc<=RESET_PC; queue emptied; outstanding<=0; drop_cnt<=0. Outputs after reset: imem_req=0 during the reset cycle, valid_if=0, pc_if=0, instruction_if=0, imem_addr=RESET_PC.
- Reset mid-operation: all in-flight requests are forgotten. Memory is reset on the same rst, so no stale responses arrive.
- State:
  - fetch_pc (BUS_WIDTH).
  - outstanding: 0..2, granted requests not yet responded to; includes requests marked for dropping.
  - drop_cnt: 0..2.
  - Queue: 2-entry FIFO of {pc, instr}, count 0..2, with a PC tag FIFO (depth 2) tracking the PC of each outstanding request.
- Credit rule: imem_req = ~rst & ~jump_en & (outstanding + count < 2). This guarantees every response finds queue space, so no response is ever lost.
- Grant: on imem_req & imem_gnt, push fetch_pc into the tag FIFO, outstanding++, and fetch_pc <= fetch_pc + 4 (modulo 2^BUS_WIDTH; 0xFFFF_FFFC wraps to 0).
- imem_addr and imem_req are held stable while imem_gnt=0.
- Response (imem_rvalid):
  - Pop the tag FIFO and do outstanding--.
  - If drop_cnt>0: discard and do drop_cnt--.
  - Otherwise: push {tag, imem_rdata} into the queue.
  - A grant and a response in the same cycle leave outstanding unchanged.
- Output:
  - valid_if = (count!=0) & ~jump_en.
  - ready_go_if = 1.
  - pc_if and instruction_if come from the queue head, registered; zero when empty.
- Pop: the head is popped when valid_if & ready_go_if & allow_in_id.
- A push and a pop in the same cycle are both honoured, and count is unchanged.
- Latency: grant at cycle N, response at N+1 at the earliest, valid_if at N+2 (no bypass from imem_rdata to outputs).
- Redirect (jump_en=1 at posedge):
  - fetch_pc <= {jump_addr[BUS_WIDTH-1:2],2'b00}.
  - Queue cleared; no pop occurs that cycle.
  - drop_cnt <= outstanding after accounting for a response in the same cycle (that response is itself discarded).
  - No request is issued in the jump cycle. The first fetch of the target occurs in the following cycle, subject to credit.
- Redirect while drop_cnt>0 already: drop_cnt is recomputed from outstanding, never exceeding 2.
- A response arriving while count+outstanding would exceed 2, or an imem_rvalid with outstanding==0, is a protocol error. Both are covered by simulation assertions, with no recovery defined.

Test Plan:
- Reset, then release with imem_gnt=1 and 1-cycle response latency, allow_in_id=1 -> imem_addr sequence 0,4,8,...; valid_if first high 2 cycles after the first grant; pc_if 0,4,8 one per cycle with matching instructions.
- Hold allow_in_id=0 from reset -> exactly 2 grants (addr 0,4), then imem_req=0 with count=2. Release allow_in_id -> pc_if 0 then 4, and fetching resumes at 8.
- imem_gnt=0 for 3 cycles with imem_req=1 -> imem_addr stays 0 and no valid_if. Assert imem_gnt -> normal flow.
- With 2 outstanding (addr 8,12), pulse jump_en with jump_addr=0x103 -> both responses discarded; next imem_addr=0x100; first valid_if has pc_if=0x100.
- jump_en in the same cycle as imem_rvalid with 1 outstanding and count=1 -> queue emptied, response dropped, drop_cnt=0, and fetch resumes at the target next cycle.
- RESET_PC=0xFFFF_FFF8 -> imem_addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_if follows the same order.
